// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO and configurable framing.
// Words queue on a valid/ready port and go out LSB first on txd.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk1mhz,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX  = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  state_t               r_state, w_state;
  logic [TW-1:0]        r_timer, w_timer;
  logic [3:0]           r_idx, w_idx;
  logic [DATA_BITS-1:0] r_shift, w_shift;
  logic                 r_par, w_par;
  logic                 r_txd, w_txd;
  logic                 r_busy;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;

  logic                 w_push, w_pop;
  logic                 w_tick, w_has;
  logic [DATA_BITS-1:0] w_head;

  assign w_head     = r_mem[r_rptr];
  assign w_has      = r_count != '0;
  assign w_tick     = r_timer == TMAX;
  assign wr_ready   = r_count != FULL;
  assign w_push     = wr_valid && wr_ready;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_par   = r_par;
    w_pop   = 1'b0;
    w_txd   = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_has) begin
          w_pop   = 1'b1;
          w_state = START;
        end
      end
      START: begin
        w_txd = 1'b0;
        if (w_tick) begin
          w_state = DATA;
          w_idx   = '0;
        end
      end
      DATA: begin
        w_txd = r_shift[0];
        if (w_tick) begin
          w_shift = r_shift >> 1;
          if (r_idx == DLAST) begin
            w_idx   = '0;
            w_state = (PARITY != 0) ? PAR : STOP;
          end else begin
            w_idx = r_idx + 4'd1;
          end
        end
      end
      PAR: begin
        w_txd = r_par;
        if (w_tick) begin
          w_state = STOP;
          w_idx   = '0;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_idx == SLAST) begin
            w_idx = '0;
            // back-to-back frames: pop straight into START
            if (w_has) begin
              w_pop   = 1'b1;
              w_state = START;
            end else begin
              w_state = IDLE;
            end
          end else begin
            w_idx = r_idx + 4'd1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_pop) begin
      w_shift = w_head;
      w_par   = (PARITY == 1) ? ~^w_head : ^w_head;
    end
    w_timer = (r_state == IDLE || w_tick) ? '0 : r_timer + 1'b1;
  end

  always_ff @(posedge clk1mhz) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk1mhz) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_txd   <= w_txd;
      // delayed one cycle so busy lines up with the registered txd
      r_busy  <= r_state != IDLE;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: default, even, odd and two-stop instances.
// Stimulus queues expected frames; per-instance monitors decode txd.
module tb_uart_tx_fifo;

  localparam int CPB = 104;

  typedef struct {
    logic [15:0] bits;
    int          n;
    longint      t;
  } exp_t;

  logic clk1mhz;
  logic reset;
  logic [7:0] wr_data, wr_data_x;
  logic wr_valid, wr_valid_x;
  logic rdy0, rdy1, rdy2, rdy3;
  logic txd0, txd1, txd2, txd3;
  logic busy0, busy1, busy2, busy3;
  logic [3:0] cnt0, cnt1, cnt2, cnt3;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  logic mon_en;
  exp_t sbq[4][$];

  uart_tx_fifo dut0 (
    .clk1mhz(clk1mhz), .reset(reset),
    .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(rdy0), .txd(txd0), .busy(busy0),
    .fifo_count(cnt0)
  );

  uart_tx_fifo #(.PARITY(2)) dut1 (
    .clk1mhz(clk1mhz), .reset(reset),
    .wr_data(wr_data_x), .wr_valid(wr_valid_x),
    .wr_ready(rdy1), .txd(txd1), .busy(busy1),
    .fifo_count(cnt1)
  );

  uart_tx_fifo #(.PARITY(1)) dut2 (
    .clk1mhz(clk1mhz), .reset(reset),
    .wr_data(wr_data_x), .wr_valid(wr_valid_x),
    .wr_ready(rdy2), .txd(txd2), .busy(busy2),
    .fifo_count(cnt2)
  );

  uart_tx_fifo #(.STOP_BITS(2)) dut3 (
    .clk1mhz(clk1mhz), .reset(reset),
    .wr_data(wr_data_x), .wr_valid(wr_valid_x),
    .wr_ready(rdy3), .txd(txd3), .busy(busy3),
    .fifo_count(cnt3)
  );

  initial begin
    clk1mhz = 1'b0;
    forever #5 clk1mhz = ~clk1mhz;
  end

  always @(posedge clk1mhz) cyc <= cyc + 1;

  function automatic logic txd_of(input int id);
    case (id)
      0:       return txd0;
      1:       return txd1;
      2:       return txd2;
      default: return txd3;
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0:       return busy0;
      1:       return busy1;
      2:       return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input int np,
                              input logic pb, input int ns,
                              input longint t);
    exp_t e;
    int k;
    e.bits = '0;
    for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
    k = 9;
    if (np != 0) begin
      e.bits[k] = pb;
      k++;
    end
    for (int i = 0; i < ns; i++) begin
      e.bits[k] = 1'b1;
      k++;
    end
    e.n = k;
    e.t = t;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cyc %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor(input int id);
    exp_t e;
    int bad;
    longint st;
    forever begin
      @(negedge clk1mhz);
      if (mon_en && !reset && txd_of(id) === 1'b0) begin
        if (sbq[id].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame dut%0d got start want idle at cyc %0d",
                   id, cyc);
          repeat (10*CPB - 1) @(negedge clk1mhz);
        end else begin
          e = sbq[id].pop_front();
          st = cyc;
          bad = 0;
          for (int c = 0; c < e.n*CPB; c++) begin
            if (c > 0) @(negedge clk1mhz);
            if (txd_of(id) !== e.bits[c/CPB] || busy_of(id) !== 1'b1)
              bad++;
          end
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL frame dut%0d got %0d bad cycles want 0 (bits %0h)",
                     id, bad, e.bits);
          end
          if (e.t >= 0) chk($sformatf("start_dut%0d", id), st, e.t);
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);
  initial monitor(3);

  task automatic wait_until(input longint t);
    while (cyc < t) @(negedge clk1mhz);
  endtask

  initial begin
    longint p;
    int lows;
    reset = 1'b1;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    wr_valid_x = 1'b0;
    wr_data_x = 8'h00;
    mon_en = 1'b1;

    repeat (3) @(negedge clk1mhz);
    chk("rst_txd", txd0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", rdy0, 1);
    chk("rst_count", cnt0, 0);
    chk("rst_x", {txd1, txd2, txd3, busy1, busy2, busy3, rdy1, rdy2, rdy3,
                  cnt1, cnt2, cnt3}, {9'b111_000_111, 12'd0});
    reset = 1'b0;
    lows = 0;
    repeat (2000) begin
      @(negedge clk1mhz);
      if (txd0 !== 1'b1) lows++;
    end
    chk("idle_quiet", lows, 0);

    // single 0x41 on every instance
    @(negedge clk1mhz);
    p = cyc;
    chk("ready_single", rdy0, 1);
    wr_data = 8'h41;
    wr_valid = 1'b1;
    wr_data_x = 8'h41;
    wr_valid_x = 1'b1;
    sbq[0].push_back(mk(8'h41, 0, 1'b0, 1, p + 3));
    sbq[1].push_back(mk(8'h41, 1, 1'b0, 1, p + 3));
    sbq[2].push_back(mk(8'h41, 1, 1'b1, 1, p + 3));
    sbq[3].push_back(mk(8'h41, 0, 1'b0, 2, p + 3));
    @(negedge clk1mhz);
    wr_valid = 1'b0;
    wr_valid_x = 1'b0;
    wr_data = 8'hFF;
    wr_data_x = 8'hFF;
    wait_until(p + 3 + 1039);
    chk("busy_last", busy0, 1);
    @(negedge clk1mhz);
    chk("busy_end", busy0, 0);
    chk("count_single", cnt0, 0);
    wait_until(p + 3 + 1143);
    chk("busy_x_last", {busy1, busy2, busy3}, 3'b111);
    @(negedge clk1mhz);
    chk("busy_x_end", {busy1, busy2, busy3}, 3'b000);

    // fill the FIFO back-to-back
    @(negedge clk1mhz);
    p = cyc;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("ready_fill%0d", k), rdy0, 1);
      wr_data = 8'(k);
      wr_valid = 1'b1;
      sbq[0].push_back(mk(8'(k), 0, 1'b0, 1, p + 3 + k*1040));
      @(negedge clk1mhz);
    end
    chk("full_ready", rdy0, 0);
    chk("full_count", cnt0, 8);
    wr_data = 8'hAA;
    @(negedge clk1mhz);
    wr_valid = 1'b0;
    chk("no_overwrite", cnt0, 8);
    wait_until(p + 1041);
    chk("pp_ready", rdy0, 0);
    chk("pp_count", cnt0, 8);
    wr_data = 8'hEE;
    wr_valid = 1'b1;
    @(negedge clk1mhz);
    wr_valid = 1'b0;
    chk("pp_ready_after", rdy0, 1);
    chk("pp_count_after", cnt0, 7);
    wait_until(p + 3 + 9*1040 + 2);
    chk("drain_txd", txd0, 1);
    chk("drain_busy", busy0, 0);
    chk("drain_count", cnt0, 0);

    // reset during DATA of first frame with 3 queued
    mon_en = 1'b0;
    @(negedge clk1mhz);
    p = cyc;
    for (int k = 0; k < 4; k++) begin
      wr_data = 8'(8'h11 * (k + 1));
      wr_valid = 1'b1;
      @(negedge clk1mhz);
    end
    wr_valid = 1'b0;
    wait_until(p + 3 + 3*CPB + 20);
    chk("pre_abort_busy", busy0, 1);
    chk("pre_abort_count", cnt0, 3);
    reset = 1'b1;
    @(negedge clk1mhz);
    reset = 1'b0;
    chk("abort_txd", txd0, 1);
    chk("abort_count", cnt0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_ready", rdy0, 1);
    mon_en = 1'b1;
    lows = 0;
    repeat (1200) begin
      @(negedge clk1mhz);
      if (txd0 !== 1'b1) lows++;
    end
    chk("abort_quiet", lows, 0);

    p = cyc;
    wr_data = 8'h55;
    wr_valid = 1'b1;
    sbq[0].push_back(mk(8'h55, 0, 1'b0, 1, p + 3));
    @(negedge clk1mhz);
    wr_valid = 1'b0;
    wait_until(p + 3 + 1040 + 2);
    chk("post_busy", busy0, 0);

    for (int id = 0; id < 4; id++)
      chk($sformatf("sb_empty%0d", id), sbq[id].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
